nf_skid_register: RTL and testbench
===================================

# nf_skid_register

Parametrised elastic pipeline register: the valid/ready successor of the plain and write-enable registers. It holds up to two words: a main output stage and a skid stage. This lets a producer and consumer exchange one word per clock while both `in_ready` and `out_valid` come straight from flops, with no combinational path from `out_ready` to `in_ready`. It sits between nanoFOX pipeline stages and between the core and bus/peripheral interfaces, wherever a timing cut with backpressure is required.

## Interface
- `width`, 32, data width in bits (≥1)
- `rst_value`, '0, value loaded into both data stages on reset (`width` bits)
- `clk`  input  1  clock, all state updated on rising edge
- `resetn`  input  1  reset; asynchronous, active-low
- `in_valid`  input  1  producer offers `in_data`
- `in_ready`  output  1  block can accept a word this cycle (registered)
- `in_data`  input  `width`  producer data
- `out_valid`  output  1  `out_data` holds a valid word (registered)
- `out_ready`  input  1  consumer accepts `out_data` this cycle
- `out_data`  output  `width`  main stage contents (registered)
- `level`  output  2  words held: 0, 1 or 2
- `flush`  input  1  synchronous discard of all contents; present only with `NF_SKID_FLUSH_EN`

## Operation
- `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- States and their outputs:
  - EMPTY: `level`=0, `out_valid`=0, `in_ready`=1.
  - ONE: `level`=1, `out_valid`=1, `in_ready`=1.
  - FULL: `level`=2, `out_valid`=1, `in_ready`=0.
- EMPTY:
  - `in_fire` -> ONE, main <= `in_data`.
  - Otherwise stay in EMPTY.
- ONE:
  - `in_fire & out_fire` -> ONE, main <= `in_data`.
  - `in_fire & !out_fire` -> FULL, skid <= `in_data`.
  - `!in_fire & out_fire` -> EMPTY.
  - Neither -> hold.
- FULL:
  - `in_fire` cannot occur.
  - `out_fire` -> ONE, main <= skid.
  - Otherwise hold.
- Data registers load only on the transitions listed above; otherwise they hold. Stale data stays in main when the block is EMPTY.
- Ordering is strict FIFO. No word is duplicated or dropped except by `flush`.
- `in_data` is ignored when `in_valid`=0. `out_ready` is ignored when `out_valid`=0.
- Producers are not required to hold `in_valid` once asserted. The block makes no protocol assumption about either side.
- Reset values:
  - State EMPTY, so `out_valid`=0, `in_ready`=1, `level`=0.
  - Main and skid = `rst_value`, so `out_data`=`rst_value`.

## Timing
- Latency: a word accepted on edge N is presented on `out_data` with `out_valid`=1 after edge N.
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- `in_ready` falls the cycle after a stall with one word held plus an accepted word (FULL). It rises the cycle after `out_fire` in FULL.
- Simultaneous `in_fire` and `out_fire` in ONE: `level` stays 1 and `out_data` updates to the new word.
- Asserting reset mid-transfer clears contents immediately (asynchronously). Release is synchronous to `clk` and gives the reset outputs on the first edge.
- All outputs are flop outputs. There are no combinational input-to-output paths.

## Configuration
- `NF_SKID_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush`=1 at an edge forces state EMPTY, regardless of `in_valid` and `out_ready`.
  - A word offered that cycle is dropped, and `out_fire` that cycle still counts as consumed.
  - Data registers are unchanged; `flush` has priority over all transitions.
- `NF_SKID_FLUSH_EN` undefined: the `flush` port and all flush logic are absent. Behaviour is exactly as in Operation.

## Test plan
- Reset with `rst_value`=32'hDEAD_BEEF -> `out_valid`=0, `in_ready`=1, `level`=0, `out_data`=32'hDEAD_BEEF. Drive `in_valid`=1 with 32'h1 -> next cycle `out_valid`=1, `out_data`=32'h1.
- Streaming: `out_ready`=1, push 1,2,3,…,16 on consecutive cycles -> outputs 1..16 on consecutive cycles, `level`=1 throughout, `in_ready` never 0.
- Backpressure: `out_ready`=0, push 5 then 6 -> `level`=2, `in_ready`=0, `out_data`=5. Raise `out_ready` -> 5 then 6 emerge on consecutive cycles, `in_ready`=1 after the first pop.
- Random `in_valid` and `out_ready` (50% each), 10k words -> the scoreboard matches in order with no loss, and `in_ready`=0 only when `level`=2.
- Reset asserted while `level`=2 -> same cycle `out_valid`=0, `in_ready`=1, `level`=0, `out_data`=`rst_value`.
- With `NF_SKID_FLUSH_EN`: fill to `level`=2 with A,B, pulse `flush` while offering C -> `level`=0. Push D -> D is the next output; A, B and C never appear.

Source files
------------

// File: rtl/nf_skid_register_if.sv
// nf_skid_register_if: valid/ready bundle for nf_skid_register.
// The flush signal exists only when NF_SKID_FLUSH_EN is defined.
interface nf_skid_register_if #(parameter int width = 32);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic [1:0]       level;
`ifdef NF_SKID_FLUSH_EN
  logic             flush;
  modport master (output in_valid, in_data, out_ready, flush, input in_ready, out_valid, out_data, level);
  modport slave  (input in_valid, in_data, out_ready, flush, output in_ready, out_valid, out_data, level);
`else
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, level);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, level);
`endif
endinterface

// File: rtl/nf_skid_register.sv
// nf_skid_register: two-word elastic register with flopped in_ready/out_valid/level.
// Optional synchronous flush is enabled by defining NF_SKID_FLUSH_EN.
module nf_skid_register #(
  parameter int               width     = 32,
  parameter logic [width-1:0] rst_value = '0
) (
  input logic               clk,
  input logic               resetn,
  nf_skid_register_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t           state_q, state_d;
  logic [width-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_ready_q, out_valid_q;
  logic [1:0]       level_q;
  logic             in_fire, out_fire;
  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d = ONE;
        main_d  = bus.in_data;
      end
      ONE: begin
        if (in_fire && out_fire) main_d = bus.in_data;
        else if (in_fire) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (out_fire) state_d = EMPTY;
      end
      FULL: if (out_fire) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
`ifdef NF_SKID_FLUSH_EN
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
`endif
  end
  // Handshake outputs are decoded from the next state so they leave the block straight from flops.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q     <= EMPTY;
      main_q      <= rst_value;
      skid_q      <= rst_value;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= state_d != FULL;
      out_valid_q <= state_d != EMPTY;
      level_q     <= state_d == FULL ? 2'd2 : state_d == ONE ? 2'd1 : 2'd0;
    end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_nf_skid_register.sv
// tb_nf_skid_register: randomized self-checking bench against a queue-based model.
// Define NF_SKID_FLUSH_EN to also exercise flush.
module tb_nf_skid_register;
  localparam logic [31:0] rv = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int fails = 0;
  int pops = 0;
  logic [31:0] q[$];
  nf_skid_register_if #(.width(32)) bus ();
  nf_skid_register #(.width(32), .rst_value(rv)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic inf, outf;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
`ifdef NF_SKID_FLUSH_EN
    bus.flush = fl;
`endif
    inf  = iv && q.size() < 2;
    outf = ordy && q.size() > 0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (outf) begin
        void'(q.pop_front());
        pops++;
      end
      if (inf) q.push_back(d);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef NF_SKID_FLUSH_EN
    bus.flush = 1'b0;
`endif
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef NF_SKID_FLUSH_EN
    bus.flush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    q.delete();
    checks += 4;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    if (bus.level !== 2'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", bus.level); end
    if (bus.out_data !== rv) begin fails++; $display("FAIL reset_out_data got %h exp %h", bus.out_data, rv); end
  endtask

  task automatic test_first;
    step(1'b1, 32'h1, 1'b0, 1'b0);
    checks += 3;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", bus.out_valid); end
    if (bus.out_data !== 32'h1) begin fails++; $display("FAIL first_data got %h exp 1", bus.out_data); end
    if (bus.level !== 2'd1) begin fails++; $display("FAIL first_level got %0d exp 1", bus.level); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL first_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_stream;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      checks += 3;
      if (bus.out_data !== 32'(i)) begin fails++; $display("FAIL stream_data[%0d] got %h exp %h", i, bus.out_data, i); end
      if (bus.level !== 2'd1) begin fails++; $display("FAIL stream_level[%0d] got %0d exp 1", i, bus.level); end
      if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.in_ready); end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b0, 1'b0);
    checks += 3;
    if (bus.level !== 2'd2) begin fails++; $display("FAIL bp_level got %0d exp 2", bus.level); end
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got %b exp 0", bus.in_ready); end
    if (bus.out_data !== 32'h5) begin fails++; $display("FAIL bp_data got %h exp 5", bus.out_data); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks += 3;
    if (bus.out_data !== 32'h6) begin fails++; $display("FAIL bp_second got %h exp 6", bus.out_data); end
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_rise got %b exp 1", bus.in_ready); end
    if (bus.level !== 2'd1) begin fails++; $display("FAIL bp_level1 got %0d exp 1", bus.level); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_random;
    int cyc = 0;
    pops = 0;
    while (pops < 10000 && cyc < 60000) begin
      step(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'b0);
      cyc++;
      checks += 3;
      if (bus.level !== 2'(q.size())) begin fails++; $display("FAIL rand_level cyc %0d got %0d exp %0d", cyc, bus.level, q.size()); end
      if (bus.in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, bus.in_ready, q.size() < 2); end
      if (bus.out_valid !== (q.size() > 0)) begin fails++; $display("FAIL rand_valid cyc %0d got %b exp %b", cyc, bus.out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++;
        if (bus.out_data !== q[0]) begin fails++; $display("FAIL rand_data cyc %0d got %h exp %h", cyc, bus.out_data, q[0]); end
      end
    end
    checks++;
    if (pops < 10000) begin fails++; $display("FAIL rand_budget got %0d words exp 10000", pops); end
    while (q.size() > 0) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midway;
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 2'd2) begin fails++; $display("FAIL mid_fill got %0d exp 2", bus.level); end
    #2 resetn = 1'b0;
    #1;
    q.delete();
    checks += 4;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b exp 1", bus.in_ready); end
    if (bus.level !== 2'd0) begin fails++; $display("FAIL mid_level got %0d exp 0", bus.level); end
    if (bus.out_data !== rv) begin fails++; $display("FAIL mid_data got %h exp %h", bus.out_data, rv); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

`ifdef NF_SKID_FLUSH_EN
  task automatic test_flush;
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    checks += 2;
    if (bus.level !== 2'd0) begin fails++; $display("FAIL flush_level got %0d exp 0", bus.level); end
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
    step(1'b1, 32'hD, 1'b0, 1'b0);
    checks += 2;
    if (bus.out_data !== 32'hD) begin fails++; $display("FAIL flush_next got %h exp d", bus.out_data); end
    if (bus.level !== 2'd1) begin fails++; $display("FAIL flush_level1 got %0d exp 1", bus.level); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_drain got %b exp 0", bus.out_valid); end
  endtask
`endif

  initial begin
    test_reset;
    test_first;
    test_stream;
    test_backpressure;
    test_random;
    test_reset_midway;
`ifdef NF_SKID_FLUSH_EN
    test_flush;
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
